// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM condition evaluation, NZCV flag register, E->M write gating
module cond_unit #(
    parameter int SKIPW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ValidE,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             CondEx,
    output logic             CondUndef,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [3:0]       Flags,
    output logic [SKIPW-1:0] SkipCount
);

    logic neg, zero, carry, ovf;
    logic go;

    assign {neg, zero, carry, ovf} = Flags;

    // Conditions read only the architectural flags; no bypass from ALUFlags.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = zero;
            4'b0001: CondEx = ~zero;
            4'b0010: CondEx = carry;
            4'b0011: CondEx = ~carry;
            4'b0100: CondEx = neg;
            4'b0101: CondEx = ~neg;
            4'b0110: CondEx = ovf;
            4'b0111: CondEx = ~ovf;
            4'b1000: CondEx = carry & ~zero;
            4'b1001: CondEx = ~carry | zero;
            4'b1010: CondEx = (neg == ovf);
            4'b1011: CondEx = (neg != ovf);
            4'b1100: CondEx = ~zero & (neg == ovf);
            4'b1101: CondEx = zero | (neg != ovf);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    assign CondUndef = ValidE & (Cond == 4'b1111);
    assign go        = ValidE & CondEx & ~flush;
    assign PCSrc     = PCS & go;
    assign RegWrite  = RegW & ~NoWrite & go;
    assign MemWrite  = MemW & go;

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags     <= 4'b0000;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            SkipCount <= '0;
        end else if (!stall) begin
            PCSrcM    <= PCSrc;
            RegWriteM <= RegWrite;
            MemWriteM <= MemWrite;
            if (go && FlagW[1])
                Flags[3:2] <= ALUFlags[3:2];
            if (go && FlagW[0])
                Flags[1:0] <= ALUFlags[1:0];
            // A flushed instruction never counts as skipped.
            if (!flush && ValidE && !CondEx && (SkipCount != '1))
                SkipCount <= SkipCount + SKIPW'(1);
        end else if (flush) begin
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit
module tb_cond_unit;

    localparam int SKIPW = 4;

    localparam int S_CONDEX  = 0;
    localparam int S_UNDEF   = 1;
    localparam int S_PCSRC   = 2;
    localparam int S_REGW    = 3;
    localparam int S_MEMW    = 4;
    localparam int S_PCSRCM  = 5;
    localparam int S_REGWM   = 6;
    localparam int S_MEMWM   = 7;
    localparam int S_FLAGS   = 8;
    localparam int S_SKIP    = 9;

    logic             clk = 1'b0;
    logic             reset, stall, flush, ValidE;
    logic [3:0]       Cond, ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             CondEx, CondUndef, PCSrc, RegWrite, MemWrite;
    logic             PCSrcM, RegWriteM, MemWriteM;
    logic [3:0]       Flags;
    logic [SKIPW-1:0] SkipCount;

    cond_unit #(.SKIPW(SKIPW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ValidE(ValidE),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .CondEx(CondEx), .CondUndef(CondUndef),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .Flags(Flags), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_sig(input int sig);
        case (sig)
            S_CONDEX: return 16'(CondEx);
            S_UNDEF:  return 16'(CondUndef);
            S_PCSRC:  return 16'(PCSrc);
            S_REGW:   return 16'(RegWrite);
            S_MEMW:   return 16'(MemWrite);
            S_PCSRCM: return 16'(PCSrcM);
            S_REGWM:  return 16'(RegWriteM);
            S_MEMWM:  return 16'(MemWriteM);
            S_FLAGS:  return 16'(Flags);
            default:  return 16'(SkipCount);
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin
        int i;
        logic [15:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc == cyc) begin
                act = get_sig(exp_q[i].sig);
                checks++;
                if (act !== exp_q[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
                             exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale expectation for cyc=%0d", exp_q[i].name, exp_q[i].cyc);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic exp_now(input int sig, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic exp_next(input int sig, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc = cyc + 1; e.sig = sig; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic regw,
                         input logic memw, input logic nowr, input logic st,
                         input logic fl, input logic rst);
        @(posedge clk);
        #1;
        ValidE = v; Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw;
        MemW = memw; NoWrite = nowr; stall = st; flush = fl; reset = rst;
    endtask

    task automatic idle();
        drive(1'b0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference table: even codes give the base test, odd codes its inverse.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cr, v, b;
        {n, z, cr, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cr;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cr & ~z;
            3'd5:    b = (n == v);
            3'd6:    b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~b : b;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 0; flush = 0; ValidE = 0; Cond = 4'hE; ALUFlags = 0;
        FlagW = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;

        // Reset state
        drive(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        exp_next(S_FLAGS, 0, "rst_flags");
        exp_next(S_SKIP, 0, "rst_skip");
        exp_next(S_REGWM, 0, "rst_regwm");
        exp_next(S_MEMWM, 0, "rst_memwm");
        exp_next(S_PCSRCM, 0, "rst_pcsrcm");

        // AL flag-setting register write
        drive(1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        exp_now(S_CONDEX, 1, "al_condex");
        exp_now(S_REGW, 1, "al_regwrite");
        exp_next(S_REGWM, 1, "al_regwm");
        exp_next(S_FLAGS, 16'h4, "al_flags");

        drive(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        exp_now(S_CONDEX, 1, "eq_pass");

        drive(1, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        exp_now(S_CONDEX, 0, "ne_fail");
        exp_now(S_REGW, 0, "ne_regwrite");
        exp_next(S_SKIP, 1, "ne_skip");
        exp_next(S_REGWM, 0, "ne_regwm");

        // Partial flag writes
        drive(1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        exp_next(S_FLAGS, 16'hF, "pw_all");
        drive(1, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        exp_next(S_FLAGS, 16'h3, "pw_nz");
        drive(1, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        exp_next(S_FLAGS, 16'h0, "pw_cv");

        // NoWrite compare, then GE failing with flags held
        drive(1, 4'hE, 4'b1000, 2'b11, 0, 1, 0, 1, 0, 0, 0);
        exp_now(S_REGW, 0, "nowrite_regwrite");
        exp_next(S_FLAGS, 16'h8, "nowrite_flags");
        exp_next(S_REGWM, 0, "nowrite_regwm");
        drive(1, 4'hA, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        exp_now(S_CONDEX, 0, "ge_fail");
        exp_next(S_FLAGS, 16'h8, "ge_noupdate");
        exp_next(S_SKIP, 2, "ge_skip");

        // Stall / flush
        drive(1, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0, 0, 0, 0);
        exp_now(S_PCSRC, 1, "wr_pcsrc");
        exp_now(S_MEMW, 1, "wr_memwrite");
        exp_next(S_MEMWM, 1, "wr_memwm");
        exp_next(S_PCSRCM, 1, "wr_pcsrcm");
        drive(1, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0, 1, 0, 0);
        exp_next(S_FLAGS, 16'h8, "stall_flags");
        exp_next(S_MEMWM, 1, "stall_memwm");
        exp_next(S_PCSRCM, 1, "stall_pcsrcm");
        drive(1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        exp_next(S_MEMWM, 0, "stflush_memwm");
        exp_next(S_PCSRCM, 0, "stflush_pcsrcm");
        exp_next(S_SKIP, 2, "stflush_skip");
        drive(1, 4'hE, 4'h0, 2'b00, 1, 0, 1, 0, 0, 1, 0);
        exp_now(S_MEMW, 0, "flush_memwrite");
        exp_now(S_PCSRC, 0, "flush_pcsrc");
        drive(1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        exp_next(S_SKIP, 2, "flush_noskip");

        // Full condition sweep over every flag value
        for (int f = 0; f < 16; f++) begin
            drive(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0, 0, 0);
            exp_next(S_FLAGS, 16'(f), "sweep_load");
            for (int c = 0; c < 16; c++) begin
                drive(1, 4'(c), 4'(~f), 2'b00, 0, 0, 0, 0, 0, 0, 0);
                exp_now(S_CONDEX, 16'(ref_cond(4'(f), 4'(c))), $sformatf("sweep_f%0h_c%0h", f, c));
                if (c == 15) exp_now(S_UNDEF, 1, "sweep_undef");
            end
        end

        // Saturation then mid-burst reset under stall
        drive(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        exp_next(S_SKIP, 0, "sat_rst");
        for (int i = 0; i < 18; i++) begin
            drive(1, 4'hF, 4'h0, 2'b11, 0, 1, 0, 0, 0, 0, 0);
            exp_next(S_SKIP, (i + 1 > 15) ? 16'hF : 16'(i + 1), $sformatf("sat_%0d", i));
        end
        drive(1, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        exp_next(S_FLAGS, 16'hA, "pre_flags");
        exp_next(S_REGWM, 1, "pre_regwm");
        exp_next(S_SKIP, 16'hF, "pre_skip");
        drive(1, 4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 1, 0, 1);
        exp_now(S_REGW, 1, "rstcomb_regwrite");
        exp_next(S_FLAGS, 0, "midrst_flags");
        exp_next(S_REGWM, 0, "midrst_regwm");
        exp_next(S_SKIP, 0, "midrst_skip");

        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover expectations actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
